// File: rtl/sd_pio_pkg.sv
// Shared register map and edge-type definitions for the SD bidirectional PIO.
package sd_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic edge_hit(input edge_type_e et, input logic cur, input logic prev);
    case (et)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/sd_pio_sync.sv
// Multi-stage input synchroniser for the PIO pins, asynchronously cleared.
module sd_pio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/sd_bidir_pio.sv
// Memory-mapped bidirectional PIO for SD CMD/DAT lines with loopback readback.
// Edge capture, mask and interrupt exist only when SD_PIO_EDGE_IRQ_EN is defined.
module sd_bidir_pio
  import sd_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_wd;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic [31:0]      w_mask_rd;
  logic [31:0]      w_edge_rd;
  logic [31:0]      r_readdata;

  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wd_unused
    logic w_unused_wd;
    assign w_unused_wd = ^writedata[31:WIDTH];
  end

  sd_pio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bidir_port),
    .o_sync  (w_sync)
  );

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    assign bidir_port[gi] = r_dir[gi] ? r_data_out[gi] : 1'bz;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_dir      <= RESET_DIR;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data_out <= w_wd;
        ADDR_DIR:    r_dir      <= w_wd;
        ADDR_OUTSET: r_data_out <= r_data_out | w_wd;
        ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wd;
        default:     ;
      endcase
    end
  end

`ifdef SD_PIO_EDGE_IRQ_EN
  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);
  // Detection stays off until the synchroniser and delay stage hold real pin data.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_w1c;
  logic [2:0]       r_arm;
  logic             r_irq;
  logic             w_armed;

  assign w_armed = (r_arm == ARM_DONE);
  assign w_w1c   = (w_wr && address == ADDR_EDGE) ? w_wd : '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign w_hit[gi] = w_armed & edge_hit(EDGE_SEL, w_sync[gi], r_prev[gi]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_arm  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_sync;
      if (!w_armed) r_arm <= r_arm + 3'd1;
      if (w_wr && address == ADDR_MASK) r_mask <= w_wd;
      // A fresh edge overrides a simultaneous clear of the same bit.
      r_edge <= (r_edge & ~w_w1c) | w_hit;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  assign irq       = r_irq;
  assign w_mask_rd = 32'(r_mask);
  assign w_edge_rd = 32'(r_edge);
`else
  logic w_unused_edge_cfg;
  assign w_unused_edge_cfg = EDGE_TYPE[0];
  assign irq       = 1'b0;
  assign w_mask_rd = '0;
  assign w_edge_rd = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(w_sync);
      ADDR_DIR:  w_rd_mux = 32'(r_dir);
      ADDR_MASK: w_rd_mux = w_mask_rd;
      ADDR_EDGE: w_rd_mux = w_edge_rd;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_sd_bidir_pio.sv
// Directed self-checking bench for sd_bidir_pio (WIDTH=4, SYNC_STAGES=2, rising edge).
// Edge/irq scenarios are compiled in when SD_PIO_EDGE_IRQ_EN is defined.
module tb_sd_bidir_pio;
  import sd_pio_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;
  wire  [WIDTH-1:0] pins;
  logic [WIDTH-1:0] tb_oe;
  logic [WIDTH-1:0] tb_drv;
  logic [31:0]      rv;
  int               checks   = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_drv
    assign pins[gi] = tb_oe[gi] ? tb_drv[gi] : 1'bz;
  end

  sd_bidir_pio #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_DIR(4'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (pins)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("wr   addr=%0d data=0x%0h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tb_oe = 4'hF; tb_drv = 4'hF;
    #2;
    check_eq("reset_readdata", readdata, 32'h0);
    check_eq("reset_irq", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Pins held high across reset release: loopback F, no capture.
    repeat (3) @(negedge clk);
    rd(ADDR_DATA, rv); check_eq("pins_high_after_reset", rv, 32'hF);
    check_eq("irq_after_reset", {31'b0, irq}, 32'h0);
    rd(ADDR_DIR, rv);  check_eq("dir_reset", rv, 32'h0);
`ifdef SD_PIO_EDGE_IRQ_EN
    rd(ADDR_EDGE, rv); check_eq("no_capture_static_high", rv, 32'h0);
`endif

    // Output setup: dir=5, data=A, outset 1, outclr 8 -> data_out=3.
    tb_oe = 4'hA; tb_drv = 4'h0;
    wr(ADDR_DIR, 32'hABCD_0005);
    wr(ADDR_DATA, 32'hFFFF_FFFA);
    wr(ADDR_OUTSET, 32'h1);
    wr(ADDR_OUTCLR, 32'h8);
    repeat (3) @(negedge clk);
    rd(ADDR_DATA, rv); check_eq("loopback_ext0", rv, 32'h1);
    rd(ADDR_DIR, rv);  check_eq("dir_readback", rv, 32'h5);
    tb_drv = 4'hA;
    repeat (3) @(negedge clk);
    rd(ADDR_DATA, rv); check_eq("loopback_ext1", rv, 32'hB);

    // Write with chipselect low is ignored.
    @(negedge clk);
    address = ADDR_DIR; writedata = 32'hF; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    rd(ADDR_DIR, rv); check_eq("cs_low_ignored", rv, 32'h5);

    wr(3'd6, 32'hF);
    rd(3'd6, rv); check_eq("addr6_zero", rv, 32'h0);
    rd(3'd7, rv); check_eq("addr7_zero", rv, 32'h0);

`ifdef SD_PIO_EDGE_IRQ_EN
    // Pin1 rising edge with mask=2.
    tb_drv = 4'h8;
    repeat (5) @(negedge clk);
    wr(ADDR_EDGE, 32'hF);
    wr(ADDR_MASK, 32'h2);
    rd(ADDR_MASK, rv); check_eq("mask_readback", rv, 32'h2);
    tb_drv = 4'hA;
    repeat (3) @(negedge clk);
    check_eq("irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check_eq("irq_asserted", {31'b0, irq}, 32'h1);
    rd(ADDR_EDGE, rv); check_eq("capture_pin1", rv, 32'h2);
    wr(ADDR_EDGE, 32'h0);
    rd(ADDR_EDGE, rv); check_eq("w0_keeps_capture", rv, 32'h2);
    wr(ADDR_EDGE, 32'h2);
    @(negedge clk);
    check_eq("irq_cleared", {31'b0, irq}, 32'h0);
    rd(ADDR_EDGE, rv); check_eq("capture_cleared", rv, 32'h0);

    // W1C on bit2 coincides with pin2 edge reaching the detector.
    wr(ADDR_DIR, 32'h1);
    tb_oe = 4'hE;
    repeat (4) @(negedge clk);
    wr(ADDR_EDGE, 32'hF);
    tb_drv = 4'hE;
    repeat (2) @(negedge clk);
    address = ADDR_EDGE; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(ADDR_EDGE, rv); check_eq("capture_beats_w1c", rv, 32'h4);
`endif

    // Drive all pins, then reset in mid-cycle.
    tb_oe = 4'h0;
    wr(ADDR_DIR, 32'hF);
    wr(ADDR_DATA, 32'hF);
    repeat (3) @(negedge clk);
    rd(ADDR_DATA, rv); check_eq("driven_all_high", rv, 32'hF);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_readdata", readdata, 32'h0);
    check_eq("async_reset_irq", {31'b0, irq}, 32'h0);
    tb_drv = 4'h0; tb_oe = 4'hF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(ADDR_DATA, rv); check_eq("pins_floated_after_reset", rv, 32'h0);
    rd(ADDR_DIR, rv);  check_eq("dir_after_mid_reset", rv, 32'h0);
`ifdef SD_PIO_EDGE_IRQ_EN
    rd(ADDR_EDGE, rv); check_eq("capture_discarded", rv, 32'h0);
`else
    // Edge logic absent: mask/capture read 0 and irq stays low.
    wr(ADDR_MASK, 32'hF);
    wr(ADDR_EDGE, 32'hF);
    tb_drv = 4'hF;
    repeat (4) @(negedge clk);
    tb_drv = 4'h5;
    repeat (4) @(negedge clk);
    rd(ADDR_MASK, rv); check_eq("mask_reads_zero", rv, 32'h0);
    rd(ADDR_EDGE, rv); check_eq("edge_reads_zero", rv, 32'h0);
    check_eq("irq_const_zero", {31'b0, irq}, 32'h0);
    rd(ADDR_DATA, rv); check_eq("pins_toggle_loopback", rv, 32'h5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
